// File: rtl/fp_subtractor_seq.sv
// fp_subtractor_seq: multi-cycle IEEE-754 single-precision subtractor (result = A - B).
// Denormals flush to zero, exponent 255 is ordinary, and the result is truncated toward zero.
module fp_subtractor_seq #(
  parameter int GUARD_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  localparam int MW = 24 + GUARD_BITS;
  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [MW:0] m_q, m_d, m_shr;
  logic [MW-1:0] s_q, s_d, ma, mb, ml, ms;
  logic [8:0] e_q, e_d, e_inc, e_dec;
  logic sign_q, sign_d, sub_q, sub_d, sb, swap;
  logic [7:0] el, es, diff;
  // Zero-exponent operands have zero magnitude, so they never win the compare.
  assign sb = ~b_q[31];
  assign ma = (a_q[30:23] == 8'd0) ? '0 : {1'b1, a_q[22:0], {GUARD_BITS{1'b0}}};
  assign mb = (b_q[30:23] == 8'd0) ? '0 : {1'b1, b_q[22:0], {GUARD_BITS{1'b0}}};
  assign swap = ((b_q[30:23] == 8'd0) ? 31'd0 : b_q[30:0]) > ((a_q[30:23] == 8'd0) ? 31'd0 : a_q[30:0]);
  assign el = swap ? b_q[30:23] : a_q[30:23];
  assign es = swap ? a_q[30:23] : b_q[30:23];
  assign ml = swap ? mb : ma;
  assign ms = swap ? ma : mb;
  assign diff = el - es;
  assign e_inc = e_q + 9'd1;
  assign e_dec = e_q - 9'd1;
  assign m_shr = m_q >> 1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      s_q      <= '0;
      e_q      <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      s_q      <= s_d;
      e_q      <= e_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      result_q <= result_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? ALIGN : IDLE;
      ALIGN:   state_d = ADDSUB;
      ADDSUB:  state_d = NORM;
      NORM:    state_d = (m_q == '0 || m_q[MW] || m_q[MW-1] || e_dec == 9'd0) ? DONE : NORM;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    s_d      = s_q;
    e_d      = e_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        a_d = in_valid ? a : a_q;
        b_d = in_valid ? b : b_q;
      end
      ALIGN: begin
        sign_d = swap ? sb : a_q[31];
        sub_d  = a_q[31] != sb;
        e_d    = {1'b0, el};
        m_d    = {1'b0, ml};
        s_d    = (diff >= 8'(MW)) ? '0 : ms >> diff;
      end
      ADDSUB: m_d = sub_q ? m_q - {1'b0, s_q} : m_q + {1'b0, s_q};
      NORM: begin
        if (m_q == '0) result_d = '0;
        else if (m_q[MW]) begin
          m_d      = m_shr;
          e_d      = e_inc;
          result_d = (e_inc >= 9'd255) ? {sign_q, 8'hFF, 23'h0} : {sign_q, e_inc[7:0], m_shr[MW-2:GUARD_BITS]};
        end else if (m_q[MW-1]) result_d = {sign_q, e_q[7:0], m_q[MW-2:GUARD_BITS]};
        else begin
          m_d      = m_q << 1;
          e_d      = e_dec;
          result_d = (e_dec == 9'd0) ? {sign_q, 31'h0} : result_q;
        end
      end
      default: ;
    endcase
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    result    = result_q;
  end
endmodule

// File: tb/tb_fp_subtractor_seq.sv
// tb_fp_subtractor_seq: directed and randomized checks of fp_subtractor_seq against a plain-arithmetic model.
module tb_fp_subtractor_seq;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b, result;
  int checks = 0;
  int failures = 0;

  fp_subtractor_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value-level model: magnitudes as integers with 3 guard bits, then a normalize loop.
  function automatic void ref_model(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output int lat);
    int ex, ey, el, es, e, d, n;
    longint mx, my, ml, ms, m;
    logic sx, sy, sl;
    bit stop;
    sx = x[31];
    sy = ~y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 0 : (longint'(x[22:0]) + (longint'(1) << 23)) * 8;
    my = (ey == 0) ? 0 : (longint'(y[22:0]) + (longint'(1) << 23)) * 8;
    if (((ey == 0) ? 0 : longint'(y[30:0])) > ((ex == 0) ? 0 : longint'(x[30:0]))) begin
      sl = sy; el = ey; ml = my; es = ex; ms = mx;
    end else begin
      sl = sx; el = ex; ml = mx; es = ey; ms = my;
    end
    d = el - es;
    ms = (d >= 27) ? 0 : ms >> d;
    m = (sx == sy) ? ml + ms : ml - ms;
    e = el;
    n = 1;
    stop = 0;
    r = 0;
    while (!stop) begin
      if (m == 0) begin
        r = 0; stop = 1;
      end else if (m >= (longint'(1) << 27)) begin
        m = m / 2; e++; stop = 1;
        r = (e >= 255) ? {sl, 8'hFF, 23'h0} : {sl, 8'(e), 23'(m >> 3)};
      end else if (m >= (longint'(1) << 26)) begin
        r = {sl, 8'(e), 23'(m >> 3)}; stop = 1;
      end else begin
        m = m * 2; e--;
        if (e == 0) begin
          r = {sl, 31'h0}; stop = 1;
        end else n++;
      end
    end
    lat = 3 + n;
  endfunction

  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    check("in_ready_before_accept", {31'h0, in_ready}, 32'd1);
    in_valid = 1; a = x; b = y;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  // Edges after the accept edge until out_valid is seen; a timeout shows up as a latency miss.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 64);
  endtask

  task automatic release_op;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    check("in_ready_after_release", {31'h0, in_ready}, 32'd1);
    check("out_valid_after_release", {31'h0, out_valid}, 32'd0);
  endtask

  logic [31:0] da [12] = '{32'h40400000, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000,
                           32'h7F7FFFFF, 32'h00C00000, 32'h00A00000, 32'h40490FDB, 32'h80000000, 32'hC0000000};
  logic [31:0] db [12] = '{32'h3F800000, 32'h3FA00000, 32'hBF800000, 32'h3F800000, 32'h40A00000, 32'h2B800000,
                           32'hFF7FFFFF, 32'h00A00000, 32'h00C00000, 32'h00000000, 32'h00000000, 32'hC0400000};
  logic [31:0] dr [12] = '{32'h40000000, 32'h3E800000, 32'h40000000, 32'h00000000, 32'hC0A00000, 32'h3F800000,
                           32'h7F800000, 32'h00000000, 32'h80000000, 32'h40490FDB, 32'h00000000, 32'h3F800000};
  int dl [12] = '{4, 6, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5};

  initial begin
    logic [31:0] x, y, er;
    int el, n, ex, ey;
    rst_n = 0; in_valid = 0; out_ready = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'h0, in_ready}, 32'd1);
    check("reset_out_valid", {31'h0, out_valid}, 32'd0);
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_result", result, 32'h0);
    rst_n = 1;

    for (int i = 0; i < 12; i++) begin
      start_op(da[i], db[i]);
      wait_done(n);
      check($sformatf("dir%0d_result", i), result, dr[i]);
      check($sformatf("dir%0d_latency", i), 32'(n), 32'(dl[i]));
      release_op();
    end

    // Backpressure: result held, new operands ignored, release coinciding with in_valid not accepted.
    start_op(32'h40400000, 32'h3F800000);
    wait_done(n);
    check("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; a = 32'h3FC00000; b = 32'h3FA00000;
      @(negedge clk);
      check("bp_result_stable", result, 32'h40000000);
      check("bp_out_valid_held", {31'h0, out_valid}, 32'd1);
      check("bp_in_ready_low", {31'h0, in_ready}, 32'd0);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0; in_valid = 0;
    @(negedge clk);
    check("bp_idle_in_ready", {31'h0, in_ready}, 32'd1);
    check("bp_idle_busy", {31'h0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("bp_no_accept_busy", {31'h0, busy}, 32'd0);
    check("bp_no_accept_out_valid", {31'h0, out_valid}, 32'd0);

    // Reset while normalizing 1.5 - 1.25.
    start_op(32'h3FC00000, 32'h3FA00000);
    repeat (3) @(negedge clk);
    check("mid_norm_busy", {31'h0, busy}, 32'd1);
    rst_n = 0;
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_busy", {31'h0, busy}, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_stale_out_valid", {31'h0, out_valid}, 32'd0);
    end

    for (int i = 0; i < 300; i++) begin
      ex = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 254));
      case ($urandom_range(0, 3))
        0: ey = ex;
        1: ey = (ex <= 1) ? ex + 1 : (ex >= 254 ? ex - 1 : ex + int'($urandom_range(0, 2)) - 1);
        2: ey = int'($urandom_range(1, 254));
        default: ey = 0;
      endcase
      x = {1'($urandom), 8'(ex), 23'($urandom)};
      y = {1'($urandom), 8'(ey), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) y[22:0] = x[22:0];
      ref_model(x, y, er, el);
      start_op(x, y);
      wait_done(n);
      check($sformatf("rnd%0d_result %h-%h", i, x, y), result, er);
      check($sformatf("rnd%0d_latency", i), 32'(n), 32'(el));
      release_op();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
